if_fetch_stage: RTL and testbench

//  - Instruction-fetch stage of the pipelined MIPS core; holds the PC register and fetches from IMEM.
//  - Consumes pc_next from the PC-source mux; produces pc_plus4, which feeds the mux npc input.
//  - Drives a req/gnt/rvalid IMEM port with one outstanding request.
//  - Presents the fetched word in a one-entry IF/ID register, with stall, redirect and a skid slot.

---
 rtl/if_fetch_stage.sv | 190 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding IMEM req/gnt/rvalid port,
// and a one-entry IF/ID register with a skid slot. Optional IF_ALIGN_CHECK_EN adds if_misalign.
//
// state | meaning
// IDLE  | out of reset, start fetching next cycle
// REQ   | imem_req asserted for pc_q, waiting for gnt
// WAIT  | request granted, waiting for rvalid (kill drops the word)
// HOLD  | word parked in skid slot until IF/ID frees up
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
`ifdef IF_ALIGN_CHECK_EN
  output logic        if_misalign,
`endif
  output logic [31:0] if_instr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;

  logic        out_free;
  logic        misalign_pc;
  logic        gnt_ok;
  logic        rv_ok;
  logic        load;
  logic [31:0] load_data;
  logic        load_fault;

`ifdef IF_ALIGN_CHECK_EN
  assign misalign_pc = (pc_q[1:0] != 2'b00);
  assign if_misalign = fault_q;
`else
  assign misalign_pc = 1'b0;
`endif

  assign out_free  = !valid_q || !stall;
  assign imem_req  = (state_q == S_REQ) && !misalign_pc;
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign pc_plus4  = pc_q + 32'd4;
  assign gnt_ok    = imem_req && imem_gnt;
  assign rv_ok     = (state_q == S_WAIT) && imem_rvalid;

  assign if_valid  = valid_q;
  assign if_pc     = epc_q;
  assign if_instr  = (valid_q && !fault_q) ? instr_q : NOP_INSTR;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    skid_d     = skid_q;
    load       = 1'b0;
    load_data  = imem_rdata;
    load_fault = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misalign_pc) begin
          // faulted PC never reaches IMEM; the entry is synthesised here
          if (out_free) begin
            load       = 1'b1;
            load_data  = NOP_INSTR;
            load_fault = 1'b1;
            pc_d       = pc_next;
          end
        end else if (gnt_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rv_ok) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (out_free) begin
            load    = 1'b1;
            pc_d    = pc_next;
            state_d = S_REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = skid_q;
          pc_d      = pc_next;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a granted or in-flight request to the old PC must be swallowed via kill
    if (redirect) begin
      load = 1'b0;
      pc_d = pc_next;
      case (state_q)
        S_REQ: begin
          if (gnt_ok) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (rv_ok) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    epc_d   = epc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    if (redirect) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      epc_d   = pc_q;
      instr_d = load_data;
      fault_d = load_fault;
    end else if (valid_q && !stall) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      skid_q  <= 32'd0;
      valid_q <= 1'b0;
      epc_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      epc_q   <= epc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: IMEM responder with adjustable latency,
// rdata = addr ^ 32'hC0DE_0000, and pc_next fed back from pc_plus4 unless redirecting.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        redirect;
  logic        stall;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_misalign;
`endif

  logic [31:0] redir_pc;
  logic        gnt_en;
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  int          checks;
  int          failures;

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_next     (pc_next),
    .redirect    (redirect),
    .stall       (stall),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
`ifdef IF_ALIGN_CHECK_EN
    .if_misalign (if_misalign),
`endif
    .if_instr    (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pc_next     = redirect ? redir_pc : pc_plus4;
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = pend && (cnt == 0);
  assign imem_rdata  = paddr ^ 32'hC0DE_0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= 32'd0;
    end else if (imem_gnt) begin
      pend  <= 1'b1;
      cnt   <= lat - 1;
      paddr <= imem_addr;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    redir_pc = 32'd0;
    gnt_en   = 1'b1;
    lat      = 1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc",    if_pc,     32'd0);
    chk("rst_instr", if_instr,  32'd0);
    chk("rst_addr",  imem_addr, 32'h0000_3000);
    chk("rst_pc4",   pc_plus4,  32'h0000_3004);
    rst_n = 1'b1;

    // back-to-back fetch, 1-cycle memory
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("seq_req",   {31'd0, imem_req}, 32'd1);
      chk("seq_addr",  imem_addr, 32'h0000_3000 + 32'(4 * k));
      tick();
      chk("seq_wreq",  {31'd0, imem_req}, 32'd0);
      chk("seq_wval",  {31'd0, if_valid}, 32'd0);
      tick();
      chk("seq_val",   {31'd0, if_valid}, 32'd1);
      chk("seq_pc",    if_pc,    32'h0000_3000 + 32'(4 * k));
      chk("seq_instr", if_instr, 32'hC0DE_3000 + 32'(4 * k));
    end

    // stall while a response arrives: word parks in the skid slot
    stall = 1'b1;
    tick();
    chk("stl_val0", {31'd0, if_valid}, 32'd1);
    chk("stl_pc0",  if_pc, 32'h0000_3008);
    tick();
    chk("stl_val1",   {31'd0, if_valid}, 32'd1);
    chk("stl_pc1",    if_pc,    32'h0000_3008);
    chk("stl_instr1", if_instr, 32'hC0DE_3008);
    chk("stl_req1",   {31'd0, imem_req}, 32'd0);
    tick();
    chk("stl_pc2",  if_pc, 32'h0000_3008);
    chk("stl_req2", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("skid_val",   {31'd0, if_valid}, 32'd1);
    chk("skid_pc",    if_pc,    32'h0000_300C);
    chk("skid_instr", if_instr, 32'hC0DE_300C);
    chk("skid_req",   {31'd0, imem_req}, 32'd1);
    chk("skid_addr",  imem_addr, 32'h0000_3010);

    // redirect while waiting on a slow response
    lat = 3;
    tick();
    chk("rw_val0", {31'd0, if_valid}, 32'd0);
    redirect = 1'b1;
    redir_pc = 32'h0000_3100;
    tick();
    redirect = 1'b0;
    chk("rw_val1", {31'd0, if_valid}, 32'd0);
    chk("rw_pc4",  pc_plus4, 32'h0000_3104);
    chk("rw_req1", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rw_req2", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rw_drop", {31'd0, if_valid}, 32'd0);
    chk("rw_req3", {31'd0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h0000_3100);
    lat = 1;
    tick();
    tick();
    chk("rw_val",   {31'd0, if_valid}, 32'd1);
    chk("rw_pc",    if_pc,    32'h0000_3100);
    chk("rw_instr", if_instr, 32'hC0DE_3100);

    // redirect coincident with rvalid
    tick();
    redirect = 1'b1;
    redir_pc = 32'h0000_3200;
    tick();
    redirect = 1'b0;
    chk("rv_drop", {31'd0, if_valid}, 32'd0);
    chk("rv_req",  {31'd0, imem_req}, 32'd1);
    chk("rv_addr", imem_addr, 32'h0000_3200);
    tick();
    tick();
    chk("rv_val",   {31'd0, if_valid}, 32'd1);
    chk("rv_pc",    if_pc,    32'h0000_3200);
    chk("rv_instr", if_instr, 32'hC0DE_3200);

    // redirect beats stall, and kills a request granted the same cycle
    stall    = 1'b1;
    redirect = 1'b1;
    redir_pc = 32'h0000_3300;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("rg_flush", {31'd0, if_valid}, 32'd0);
    chk("rg_pc4",   pc_plus4, 32'h0000_3304);
    tick();
    chk("rg_drop",  {31'd0, if_valid}, 32'd0);
    chk("rg_addr",  imem_addr, 32'h0000_3300);
    tick();
    tick();
    chk("rg_val",   {31'd0, if_valid}, 32'd1);
    chk("rg_pc",    if_pc,    32'h0000_3300);
    chk("rg_instr", if_instr, 32'hC0DE_3300);

    // redirect in REQ without gnt, then PC wrap at the top of memory
    gnt_en   = 1'b0;
    redirect = 1'b1;
    redir_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wr_req",  {31'd0, imem_req}, 32'd1);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_pc4",  pc_plus4,  32'h0000_0000);
    gnt_en = 1'b1;
    tick();
    tick();
    chk("wr_pc",    if_pc,     32'hFFFF_FFFC);
    chk("wr_instr", if_instr,  32'h3F21_FFFC);
    chk("wr_next",  imem_addr, 32'h0000_0000);

    // reset in the middle of WAIT
    lat = 3;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_req",   {31'd0, imem_req}, 32'd0);
    chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_pc",    if_pc,     32'd0);
    chk("mr_instr", if_instr,  32'd0);
    chk("mr_addr",  imem_addr, 32'h0000_3000);
    tick();
    tick();
    rst_n = 1'b1;
    lat   = 1;
    tick();
    chk("mr_req2",  {31'd0, imem_req}, 32'd1);
    chk("mr_addr2", imem_addr, 32'h0000_3000);
    tick();
    tick();
    chk("mr_val",   {31'd0, if_valid}, 32'd1);
    chk("mr_fpc",   if_pc,    32'h0000_3000);
    chk("mr_finst", if_instr, 32'hC0DE_3000);

`ifdef IF_ALIGN_CHECK_EN
    gnt_en   = 1'b0;
    redirect = 1'b1;
    redir_pc = 32'h0000_3102;
    tick();
    redirect = 1'b0;
    stall    = 1'b1;
    chk("ma_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("ma_val",   {31'd0, if_valid},    32'd1);
    chk("ma_flag",  {31'd0, if_misalign}, 32'd1);
    chk("ma_instr", if_instr, 32'd0);
    chk("ma_pc",    if_pc,    32'h0000_3102);
    chk("ma_req2",  {31'd0, imem_req}, 32'd0);
    tick();
    chk("ma_hold",  {31'd0, if_misalign}, 32'd1);
    redirect = 1'b1;
    redir_pc = 32'h0000_3000;
    gnt_en   = 1'b1;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("ma_clr",  {31'd0, if_misalign}, 32'd0);
    chk("ma_vclr", {31'd0, if_valid},    32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
